// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: serves loads and stores
// after LATENCY edges, stalling the upstream pipeline while the access is in flight.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        Stall_o,
  output logic        Ack_o,
  output logic        Err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state, state_next;
  logic [3:0]          count;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_wdata;
  logic [31:0]         mem [DEPTH];

  logic                req, illegal;
  logic [ADDR_W-1:0]   in_idx;
  logic                access_fire, acc_write;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;

  // Upper address bits are deliberately dropped so addresses wrap modulo the array size.
  logic unused_addr;
  assign unused_addr = &{1'b0, Addr_i[31:ADDR_W+2], 1'b0};

  assign req     = MemRead_i | MemWrite_i;
  assign illegal = req & ((Addr_i[1:0] != 2'b00) | (MemRead_i & MemWrite_i));
  assign in_idx  = Addr_i[ADDR_W+1:2];

  // With LATENCY==1 the access happens on the acceptance edge, so it uses the live inputs.
  always_comb begin
    state_next  = state;
    Stall_o     = 1'b0;
    Ack_o       = 1'b0;
    Err_o       = 1'b0;
    access_fire = 1'b0;
    acc_write   = lat_write;
    acc_idx     = lat_idx;
    acc_wdata   = lat_wdata;
    case (state)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            Err_o = 1'b1;
          end else begin
            Stall_o = 1'b1;
            if (LATENCY == 1) begin
              state_next  = DONE;
              access_fire = 1'b1;
              acc_write   = MemWrite_i;
              acc_idx     = in_idx;
              acc_wdata   = WriteData_i;
            end else begin
              state_next = BUSY;
            end
          end
        end
      end
      BUSY: begin
        Stall_o = 1'b1;
        if (count == 4'd1) begin
          state_next  = DONE;
          access_fire = 1'b1;
        end
      end
      DONE: begin
        Ack_o      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset must release the pipeline at once and abandon any pending access.
    if (rst_i) begin
      Stall_o     = 1'b0;
      Ack_o       = 1'b0;
      Err_o       = 1'b0;
      access_fire = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= 4'd0;
      lat_write  <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= 32'd0;
      ReadData_o <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && req && !illegal) begin
        count     <= LAT_M1;
        lat_write <= MemWrite_i;
        lat_idx   <= in_idx;
        lat_wdata <= WriteData_i;
      end else if (state == BUSY) begin
        count <= count - 4'd1;
      end
      if (access_fire && !acc_write) begin
        ReadData_o <= mem[acc_idx];
      end
    end
  end

  // The array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (access_fire && acc_write) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: one instance at LATENCY=3,
// one at LATENCY=1, sharing clock and reset.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd3, wr3, rd1, wr1;
  logic [31:0] addr3, wd3, addr1, wd1;
  logic [31:0] rdata3, rdata1;
  logic        stall3, ack3, err3, stall1, ack1, err1;

  int          checks;
  int          failures;

  int          stalls;
  logic        ack_seen;
  logic [31:0] rdata_seen;
  int          ack_count;

  data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd3), .MemWrite_i(wr3), .Addr_i(addr3),
    .WriteData_i(wd3), .ReadData_o(rdata3), .Stall_o(stall3), .Ack_o(ack3), .Err_o(err3)
  );

  data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1), .Addr_i(addr1),
    .WriteData_i(wd1), .ReadData_o(rdata1), .Stall_o(stall1), .Ack_o(ack1), .Err_o(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request at a negedge, hold it while stalled, and capture the completion cycle.
  task automatic issue(input bit fast, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, output int n_stall,
                       output logic ack, output logic [31:0] rdata);
    @(negedge clk);
    if (fast) begin
      rd1 = !wr; wr1 = wr; addr1 = addr; wd1 = data;
    end else begin
      rd3 = !wr; wr3 = wr; addr3 = addr; wd3 = data;
    end
    n_stall = 0;
    #1;
    while ((fast ? stall1 : stall3) && n_stall < 20) begin
      n_stall++;
      @(negedge clk);
      #1;
    end
    ack   = fast ? ack1 : ack3;
    rdata = fast ? rdata1 : rdata3;
    rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd3 = 1'b0; wr3 = 1'b0; addr3 = 32'd0; wd3 = 32'd0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({rdata3, stall3, ack3, err3} !== {32'd0, 3'b000}) begin
      failures++;
      $display("[TB] FAIL reset_state: rdata=%h stall=%b ack=%b err=%b, want 0/0/0/0",
               rdata3, stall3, ack3, err3);
    end
    checks++;
    if ({rdata1, stall1, ack1, err1} !== {32'd0, 3'b000}) begin
      failures++;
      $display("[TB] FAIL reset_state_fast: rdata=%h stall=%b ack=%b err=%b, want 0", rdata1, stall1, ack1, err1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, stalls, ack_seen, rdata_seen);
    checks++;
    if (stalls !== 3) begin
      failures++;
      $display("[TB] FAIL store_stall_len: got %0d, want 3", stalls);
    end
    checks++;
    if (ack_seen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL store_ack: got %b, want 1", ack_seen);
    end
    checks++;
    if (rdata_seen !== 32'd0) begin
      failures++;
      $display("[TB] FAIL store_keeps_rdata: got %h, want 00000000", rdata_seen);
    end
    issue(1'b0, 1'b0, 32'h10, 32'h0, stalls, ack_seen, rdata_seen);
    checks++;
    if (stalls !== 3 || ack_seen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_timing: stalls=%0d ack=%b, want 3/1", stalls, ack_seen);
    end
    checks++;
    if (rdata_seen !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL load_data: got %h, want deadbeef", rdata_seen);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ack3 !== 1'b0 || stall3 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_one_cycle: ack=%b stall=%b, want 0/0", ack3, stall3);
    end
  endtask

  task automatic test_illegal();
    rd3 = 1'b1; addr3 = 32'h13;
    #1;
    checks++;
    if ({err3, stall3} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL misaligned_err: err=%b stall=%b, want 1/0", err3, stall3);
    end
    @(negedge clk);
    rd3 = 1'b1; wr3 = 1'b1; addr3 = 32'h20;
    #1;
    checks++;
    if ({err3, stall3, ack3} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL both_ops_err: err=%b stall=%b ack=%b, want 1/0/0", err3, stall3, ack3);
    end
    @(negedge clk);
    rd3 = 1'b0; wr3 = 1'b0;
    #1;
    checks++;
    if ({err3, stall3, ack3} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL illegal_stays_idle: err=%b stall=%b ack=%b, want 0/0/0", err3, stall3, ack3);
    end
    checks++;
    if (rdata3 !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL illegal_rdata_hold: got %h, want deadbeef", rdata3);
    end
  endtask

  task automatic test_reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rdata3, stall3, ack3, err3} !== {32'd0, 3'b000}) begin
      failures++;
      $display("[TB] FAIL midsim_reset: rdata=%h stall=%b ack=%b err=%b, want 0/0/0/0",
               rdata3, stall3, ack3, err3);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    issue(1'b0, 1'b1, 32'h1000, 32'h12345678, stalls, ack_seen, rdata_seen);
    issue(1'b0, 1'b0, 32'h0, 32'h0, stalls, ack_seen, rdata_seen);
    checks++;
    if (rdata_seen !== 32'h12345678 || ack_seen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_load: got %h ack=%b, want 12345678/1", rdata_seen, ack_seen);
    end
  endtask

  task automatic test_reset_busy();
    issue(1'b0, 1'b1, 32'h4, 32'hAA, stalls, ack_seen, rdata_seen);
    @(negedge clk);
    wr3 = 1'b1; addr3 = 32'h4; wd3 = 32'h55;
    @(negedge clk);
    #1;
    checks++;
    if (stall3 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_stall: got %b, want 1", stall3);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({stall3, ack3, rdata3} !== {2'b00, 32'd0}) begin
      failures++;
      $display("[TB] FAIL busy_reset_release: stall=%b ack=%b rdata=%h, want 0/0/0", stall3, ack3, rdata3);
    end
    wr3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 1'b0, 32'h4, 32'h0, stalls, ack_seen, rdata_seen);
    checks++;
    if (rdata_seen !== 32'hAA || stalls !== 3) begin
      failures++;
      $display("[TB] FAIL store_discarded: got %h stalls=%0d, want 000000aa/3", rdata_seen, stalls);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b1, 32'h10, 32'hA1A1A1A1, stalls, ack_seen, rdata_seen);
    checks++;
    if (stalls !== 1 || ack_seen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fast_store_timing: stalls=%0d ack=%b, want 1/1", stalls, ack_seen);
    end
    issue(1'b1, 1'b1, 32'h14, 32'hB2B2B2B2, stalls, ack_seen, rdata_seen);
    ack_count = 0;
    @(negedge clk);
    rd1 = 1'b1; addr1 = 32'h10;
    #1;
    checks++;
    if ({stall1, ack1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL b2b_c0: stall=%b ack=%b, want 1/0", stall1, ack1);
    end
    @(negedge clk);
    #1;
    if (ack1 === 1'b1) ack_count++;
    checks++;
    if ({stall1, ack1, rdata1} !== {2'b01, 32'hA1A1A1A1}) begin
      failures++;
      $display("[TB] FAIL b2b_c1: stall=%b ack=%b rdata=%h, want 0/1/a1a1a1a1", stall1, ack1, rdata1);
    end
    @(negedge clk);
    addr1 = 32'h14;
    #1;
    checks++;
    if ({stall1, ack1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL b2b_c2: stall=%b ack=%b, want 1/0", stall1, ack1);
    end
    @(negedge clk);
    #1;
    if (ack1 === 1'b1) ack_count++;
    checks++;
    if ({stall1, ack1, rdata1} !== {2'b01, 32'hB2B2B2B2}) begin
      failures++;
      $display("[TB] FAIL b2b_c3: stall=%b ack=%b rdata=%h, want 0/1/b2b2b2b2", stall1, ack1, rdata1);
    end
    rd1 = 1'b0;
    @(negedge clk);
    #1;
    if (ack1 === 1'b1) ack_count++;
    checks++;
    if (ack_count !== 2 || stall1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_ack_count: acks=%0d stall=%b, want 2/0", ack_count, stall1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_store_load();
    test_illegal();
    test_reset_pulse();
    test_wrap();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
